// File: rtl/pcie_crdt_pkg.sv
// Shared encodings for the PCIe UP credit tracker: TLP types, update-bit
// positions, tracker state and the saturating adder used by every counter.
package pcie_crdt_pkg;

    localparam logic [1:0] TLP_P    = 2'd0;
    localparam logic [1:0] TLP_NP   = 2'd1;
    localparam logic [1:0] TLP_CPL  = 2'd2;
    localparam logic [1:0] TLP_RSVD = 2'd3;

    localparam int UPD_PH   = 5;
    localparam int UPD_NPH  = 4;
    localparam int UPD_CPLH = 3;
    localparam int UPD_PD   = 2;
    localparam int UPD_NPD  = 1;
    localparam int UPD_CPLD = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } crdt_state_e;

    // Callers zero-extend into 32 bits and pass their own all-ones ceiling.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            sat_add = max;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/pcie_crdt_up_tracker_if.sv
// Request/credit bundle between the UP transmit path and the credit tracker.
// PCIE_CRDT_STALL_CNT_EN adds the CRDT_STALL_CNT observation counter.
interface pcie_crdt_up_tracker_if #(
    parameter int SEGMENTS = 2,
    parameter int H_CNT_W  = 2,
    parameter int D_CNT_W  = 4,
    parameter int REQ_D_W  = 8
);
    logic                          CRDT_INIT_DONE;
    logic [5:0]                    CRDT_UPDATE;
    logic [H_CNT_W-1:0]            CRDT_CNT_PH;
    logic [H_CNT_W-1:0]            CRDT_CNT_NPH;
    logic [H_CNT_W-1:0]            CRDT_CNT_CPLH;
    logic [D_CNT_W-1:0]            CRDT_CNT_PD;
    logic [D_CNT_W-1:0]            CRDT_CNT_NPD;
    logic [D_CNT_W-1:0]            CRDT_CNT_CPLD;
    logic [SEGMENTS-1:0]           REQ_VLD;
    logic [SEGMENTS*2-1:0]         REQ_TYPE;
    logic [SEGMENTS*REQ_D_W-1:0]   REQ_DCRDT;
    logic [SEGMENTS-1:0]           REQ_GRANT;
    logic                          CRDT_READY;
    logic [5:0]                    CRDT_INFINITE;
`ifdef PCIE_CRDT_STALL_CNT_EN
    logic [31:0]                   CRDT_STALL_CNT;
`endif

    modport master (
        output CRDT_INIT_DONE, CRDT_UPDATE,
        output CRDT_CNT_PH, CRDT_CNT_NPH, CRDT_CNT_CPLH,
        output CRDT_CNT_PD, CRDT_CNT_NPD, CRDT_CNT_CPLD,
        output REQ_VLD, REQ_TYPE, REQ_DCRDT,
        input  REQ_GRANT, CRDT_READY, CRDT_INFINITE
`ifdef PCIE_CRDT_STALL_CNT_EN
        , input CRDT_STALL_CNT
`endif
    );

    modport slave (
        input  CRDT_INIT_DONE, CRDT_UPDATE,
        input  CRDT_CNT_PH, CRDT_CNT_NPH, CRDT_CNT_CPLH,
        input  CRDT_CNT_PD, CRDT_CNT_NPD, CRDT_CNT_CPLD,
        input  REQ_VLD, REQ_TYPE, REQ_DCRDT,
        output REQ_GRANT, CRDT_READY, CRDT_INFINITE
`ifdef PCIE_CRDT_STALL_CNT_EN
        , output CRDT_STALL_CNT
`endif
    );

endinterface

// File: rtl/pcie_crdt_counter.sv
// One link-partner credit counter: debit of granted credits, saturating
// credit return, and an infinite flag captured when initialisation completes.
module pcie_crdt_counter
    import pcie_crdt_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             upd_vld_i,
    input  logic [CNT_W-1:0] upd_cnt_i,
    input  logic [W-1:0]     debit_i,
    input  logic             latch_inf_i,
    output logic [W-1:0]     cnt_o,
    output logic             inf_o
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic [W-1:0] cnt_q, cnt_d, base_s;
    logic         inf_q, inf_d;

    // Debit first (never below zero since grants only use what is present), then credit return.
    always_comb begin
        if (inf_q) begin
            base_s = cnt_q;
        end else begin
            base_s = cnt_q - debit_i;
        end
        if (upd_vld_i) begin
            cnt_d = W'(sat_add(32'(base_s), 32'(upd_cnt_i), 32'(CNT_MAX)));
        end else begin
            cnt_d = base_s;
        end
        if (latch_inf_i) begin
            inf_d = (cnt_d == CNT_ZERO);
        end else begin
            inf_d = inf_q;
        end
    end

    // Counter and infinite-flag state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CNT_ZERO;
            inf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inf_q <= inf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign inf_o = inf_q;

endmodule

// File: rtl/pcie_crdt_up_tracker.sv
// Credit-gated UP (CC+RQ) transmit arbiter: grants an in-order prefix of TLP
// starts whose credits fit. Optional PCIE_CRDT_STALL_CNT_EN adds a stall counter.
module pcie_crdt_up_tracker
    import pcie_crdt_pkg::*;
#(
    parameter int SEGMENTS = 2,
    parameter int H_CNT_W  = 2,
    parameter int D_CNT_W  = 4,
    parameter int H_CRDT_W = 8,
    parameter int D_CRDT_W = 12,
    parameter int REQ_D_W  = 8
) (
    input  logic                  PCIE_CLK,
    input  logic                  PCIE_RESET,
    pcie_crdt_up_tracker_if.slave bus
);

    localparam int HW = H_CRDT_W + 3;
    localparam int DW = ((D_CRDT_W > REQ_D_W) ? D_CRDT_W : REQ_D_W) + 3;
    localparam logic [HW-1:0] H_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
    localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};

    crdt_state_e state_q, state_d;
    logic        run_s, latch_inf_s;

    // Index 0/1/2 follows the TLP type encoding P/NP/CPL.
    logic [2:0][H_CRDT_W-1:0] h_cnt_s, h_debit_s;
    logic [2:0][D_CRDT_W-1:0] d_cnt_s, d_debit_s;
    logic [2:0]               h_inf_s, d_inf_s;
    logic [SEGMENTS-1:0]      grant_s;

    // State register.
    always_ff @(posedge PCIE_CLK) begin
        if (PCIE_RESET) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN is sticky until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = bus.CRDT_INIT_DONE ? ST_RUN : ST_INIT;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        run_s       = 1'b0;
        latch_inf_s = 1'b0;
        case (state_q)
            ST_INIT: latch_inf_s = bus.CRDT_INIT_DONE;
            ST_RUN:  run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
    end

    pcie_crdt_counter #(.W(H_CRDT_W), .CNT_W(H_CNT_W)) u_cnt_ph (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_PH]),
        .upd_cnt_i(bus.CRDT_CNT_PH), .debit_i(h_debit_s[0]), .latch_inf_i(latch_inf_s),
        .cnt_o(h_cnt_s[0]), .inf_o(h_inf_s[0]));
    pcie_crdt_counter #(.W(H_CRDT_W), .CNT_W(H_CNT_W)) u_cnt_nph (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_NPH]),
        .upd_cnt_i(bus.CRDT_CNT_NPH), .debit_i(h_debit_s[1]), .latch_inf_i(latch_inf_s),
        .cnt_o(h_cnt_s[1]), .inf_o(h_inf_s[1]));
    pcie_crdt_counter #(.W(H_CRDT_W), .CNT_W(H_CNT_W)) u_cnt_cplh (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_CPLH]),
        .upd_cnt_i(bus.CRDT_CNT_CPLH), .debit_i(h_debit_s[2]), .latch_inf_i(latch_inf_s),
        .cnt_o(h_cnt_s[2]), .inf_o(h_inf_s[2]));
    pcie_crdt_counter #(.W(D_CRDT_W), .CNT_W(D_CNT_W)) u_cnt_pd (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_PD]),
        .upd_cnt_i(bus.CRDT_CNT_PD), .debit_i(d_debit_s[0]), .latch_inf_i(latch_inf_s),
        .cnt_o(d_cnt_s[0]), .inf_o(d_inf_s[0]));
    pcie_crdt_counter #(.W(D_CRDT_W), .CNT_W(D_CNT_W)) u_cnt_npd (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_NPD]),
        .upd_cnt_i(bus.CRDT_CNT_NPD), .debit_i(d_debit_s[1]), .latch_inf_i(latch_inf_s),
        .cnt_o(d_cnt_s[1]), .inf_o(d_inf_s[1]));
    pcie_crdt_counter #(.W(D_CRDT_W), .CNT_W(D_CNT_W)) u_cnt_cpld (
        .clk_i(PCIE_CLK), .rst_i(PCIE_RESET), .upd_vld_i(bus.CRDT_UPDATE[UPD_CPLD]),
        .upd_cnt_i(bus.CRDT_CNT_CPLD), .debit_i(d_debit_s[2]), .latch_inf_i(latch_inf_s),
        .cnt_o(d_cnt_s[2]), .inf_o(d_inf_s[2]));

    for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
        logic [2:0][HW-1:0]  cum_h_in_s, cum_h_out_s, try_h_s;
        logic [2:0][DW-1:0]  cum_d_in_s, cum_d_out_s, try_d_s;
        logic                ok_in_s, ok_out_s, fit_s;
        logic [1:0]          typ_s;
        logic [REQ_D_W-1:0]  dreq_s;

        if (s == 0) begin : g_first
            assign cum_h_in_s = {(3*HW){1'b0}};
            assign cum_d_in_s = {(3*DW){1'b0}};
            assign ok_in_s    = run_s;
        end else begin : g_next
            assign cum_h_in_s = g_seg[s-1].cum_h_out_s;
            assign cum_d_in_s = g_seg[s-1].cum_d_out_s;
            assign ok_in_s    = g_seg[s-1].ok_out_s;
        end

        assign typ_s  = bus.REQ_TYPE[2*s +: 2];
        assign dreq_s = bus.REQ_DCRDT[s*REQ_D_W +: REQ_D_W];

        // This segment's demand stacked on everything granted below it.
        always_comb begin
            fit_s = (typ_s != TLP_RSVD);
            for (int k = 0; k < 3; k++) begin
                try_h_s[k] = cum_h_in_s[k] + ((typ_s == 2'(k)) ? H_ONE : H_ZERO);
                try_d_s[k] = cum_d_in_s[k] + ((typ_s == 2'(k)) ? DW'(dreq_s) : D_ZERO);
                fit_s = fit_s & ((typ_s != 2'(k)) |
                                 ((h_inf_s[k] | (try_h_s[k] <= HW'(h_cnt_s[k]))) &
                                  (d_inf_s[k] | (try_d_s[k] <= DW'(d_cnt_s[k])))));
            end
        end

        assign grant_s[s]  = ok_in_s & bus.REQ_VLD[s] & fit_s;
        assign ok_out_s    = ok_in_s & (~bus.REQ_VLD[s] | grant_s[s]);
        assign cum_h_out_s = grant_s[s] ? try_h_s : cum_h_in_s;
        assign cum_d_out_s = grant_s[s] ? try_d_s : cum_d_in_s;
    end

    // Total granted consumption per type feeds the counter debit ports.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            h_debit_s[k] = H_CRDT_W'(g_seg[SEGMENTS-1].cum_h_out_s[k]);
            d_debit_s[k] = D_CRDT_W'(g_seg[SEGMENTS-1].cum_d_out_s[k]);
        end
    end

    assign bus.REQ_GRANT     = grant_s;
    assign bus.CRDT_READY    = (state_q == ST_RUN);
    assign bus.CRDT_INFINITE = {h_inf_s[0], h_inf_s[1], h_inf_s[2],
                                d_inf_s[0], d_inf_s[1], d_inf_s[2]};

`ifdef PCIE_CRDT_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // RUN cycles where some valid segment was held back.
    always_comb begin
        if (run_s && (|(bus.REQ_VLD & ~grant_s)) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge PCIE_CLK) begin
        if (PCIE_RESET) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.CRDT_STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_pcie_crdt_up_tracker.sv
// Scoreboard bench for pcie_crdt_up_tracker with SEGMENTS=2 and default widths.
module tb_pcie_crdt_up_tracker;

    logic pcie_clk;
    logic pcie_reset;
    int   n_chk;
    int   n_pass;

    typedef struct {
        string      tag;
        logic [1:0] grant;
        logic       ready;
    } exp_t;

    exp_t sb_q[$];

    pcie_crdt_up_tracker_if #(.SEGMENTS(2), .H_CNT_W(2), .D_CNT_W(4), .REQ_D_W(8)) bus ();

    pcie_crdt_up_tracker #(
        .SEGMENTS(2), .H_CNT_W(2), .D_CNT_W(4),
        .H_CRDT_W(8), .D_CRDT_W(12), .REQ_D_W(8)
    ) dut (
        .PCIE_CLK   (pcie_clk),
        .PCIE_RESET (pcie_reset),
        .bus        (bus)
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs(input logic [1:0] vld, input logic [3:0] typ,
                                input logic [15:0] dcr, input logic [5:0] upd,
                                input logic [1:0] hc, input logic [3:0] dc,
                                input logic done);
        bus.REQ_VLD        = vld;
        bus.REQ_TYPE       = typ;
        bus.REQ_DCRDT      = dcr;
        bus.CRDT_UPDATE    = upd;
        bus.CRDT_CNT_PH    = hc;
        bus.CRDT_CNT_NPH   = hc;
        bus.CRDT_CNT_CPLH  = hc;
        bus.CRDT_CNT_PD    = dc;
        bus.CRDT_CNT_NPD   = dc;
        bus.CRDT_CNT_CPLD  = dc;
        bus.CRDT_INIT_DONE = done;
    endtask

    // One clock of stimulus; expected grant/ready queued, compared mid-cycle.
    task automatic cycle(input string tag, input logic [1:0] vld, input logic [3:0] typ,
                         input logic [15:0] dcr, input logic [5:0] upd,
                         input logic [1:0] hc, input logic [3:0] dc, input logic done,
                         input logic [1:0] exp_g, input logic exp_rdy);
        exp_t e;
        @(posedge pcie_clk);
        #1;
        drive_inputs(vld, typ, dcr, upd, hc, dc, done);
        e.tag   = tag;
        e.grant = exp_g;
        e.ready = exp_rdy;
        sb_q.push_back(e);
        @(negedge pcie_clk);
        e = sb_q.pop_front();
        check_val({e.tag, "/grant"}, 32'(bus.REQ_GRANT), 32'(e.grant));
        check_val({e.tag, "/ready"}, 32'(bus.CRDT_READY), 32'(e.ready));
    endtask

    // Reset with both segments requesting; everything must read back cleared.
    task automatic do_reset(input string tag);
        @(posedge pcie_clk);
        #1;
        pcie_reset = 1'b1;
        drive_inputs(2'b11, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0);
        @(posedge pcie_clk);
        #1;
        pcie_reset = 1'b0;
        check_val({tag, "/rst_grant"}, 32'(bus.REQ_GRANT), 32'd0);
        check_val({tag, "/rst_ready"}, 32'(bus.CRDT_READY), 32'd0);
        check_val({tag, "/rst_inf"}, 32'(bus.CRDT_INFINITE), 32'd0);
        check_val({tag, "/rst_ph"}, 32'(dut.u_cnt_ph.cnt_q), 32'd0);
        check_val({tag, "/rst_pd"}, 32'(dut.u_cnt_pd.cnt_q), 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        pcie_reset = 1'b1;
        drive_inputs(2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0);
        do_reset("por");

        // INIT gating: PH accumulates 9, nothing granted until READY.
        cycle("ig0", 2'b11, 4'b0000, 16'h0000, 6'b100000, 2'd3, 4'd0, 1'b0, 2'b00, 1'b0);
        cycle("ig1", 2'b11, 4'b0000, 16'h0000, 6'b100000, 2'd3, 4'd0, 1'b0, 2'b00, 1'b0);
        cycle("ig_done", 2'b11, 4'b0000, 16'h0000, 6'b100000, 2'd3, 4'd0, 1'b1, 2'b00, 1'b0);
        cycle("ig_run", 2'b11, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b11, 1'b1);
        check_val("ig_inf", 32'(bus.CRDT_INFINITE), 32'h1F);
        check_val("ig_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd9);

        // Infinite detect: PH=4, PD=16, the rest infinite.
        do_reset("inf");
        cycle("if0", 2'b00, 4'b0000, 16'h0000, 6'b100100, 2'd2, 4'd8, 1'b0, 2'b00, 1'b0);
        cycle("if1", 2'b00, 4'b0000, 16'h0000, 6'b100100, 2'd2, 4'd8, 1'b0, 2'b00, 1'b0);
        cycle("if_done", 2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("if_cpl", 2'b11, 4'b1010, {8'd5, 8'd5}, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b11, 1'b1);
        end
        check_val("if_inf", 32'(bus.CRDT_INFINITE), 32'h1B);
        cycle("if_rsv0", 2'b11, 4'b1011, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b00, 1'b1);
        cycle("if_rsv1", 2'b11, 4'b1110, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b01, 1'b1);
        check_val("if_cplh", 32'(dut.u_cnt_cplh.cnt_q), 32'd0);
        check_val("if_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd4);
        check_val("if_pd", 32'(dut.u_cnt_pd.cnt_q), 32'd16);

        // Prefix block on header credits.
        do_reset("pfx");
        cycle("pf_init", 2'b00, 4'b0000, 16'h0000, 6'b100100, 2'd1, 4'd8, 1'b1, 2'b00, 1'b0);
        cycle("pf", 2'b11, 4'b0000, {8'd2, 8'd4}, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b01, 1'b1);
        cycle("pf_idle", 2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b00, 1'b1);
        check_val("pf_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd0);
        check_val("pf_pd", 32'(dut.u_cnt_pd.cnt_q), 32'd4);

        // Data limit, then release by a PD update of 1 (seg0 idle never blocks).
        do_reset("dlim");
        cycle("dl_init", 2'b00, 4'b0000, 16'h0000, 6'b100100, 2'd2, 4'd5, 1'b1, 2'b00, 1'b0);
        cycle("dl_two", 2'b11, 4'b0000, {8'd3, 8'd3}, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b01, 1'b1);
        cycle("dl_short", 2'b10, 4'b0000, {8'd3, 8'd0}, 6'b000100, 2'd0, 4'd1, 1'b0, 2'b00, 1'b1);
        cycle("dl_upd", 2'b10, 4'b0000, {8'd3, 8'd0}, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b10, 1'b1);
        cycle("dl_idle", 2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b00, 1'b1);
        check_val("dl_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd0);
        check_val("dl_pd", 32'(dut.u_cnt_pd.cnt_q), 32'd0);

        // Grant and update in one cycle, then saturation of PH.
        do_reset("sim");
        cycle("sim_init", 2'b00, 4'b0000, 16'h0000, 6'b100000, 2'd1, 4'd0, 1'b1, 2'b00, 1'b0);
        cycle("sim_grant", 2'b01, 4'b0000, 16'h0000, 6'b100000, 2'd3, 4'd0, 1'b0, 2'b01, 1'b1);
        cycle("sim_chk", 2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b00, 1'b1);
        check_val("sim_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd3);
        for (int i = 0; i < 84; i++) begin
            cycle("sat_fill", 2'b00, 4'b0000, 16'h0000, 6'b100000, 2'd3, 4'd0, 1'b0, 2'b00, 1'b1);
        end
        cycle("sat_add", 2'b00, 4'b0000, 16'h0000, 6'b100000, 2'd2, 4'd0, 1'b0, 2'b00, 1'b1);
        check_val("sat_full", 32'(dut.u_cnt_ph.cnt_q), 32'hFF);
        cycle("sat_chk", 2'b00, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b00, 1'b1);
        check_val("sat_ph", 32'(dut.u_cnt_ph.cnt_q), 32'hFF);

        // Reset mid-run with credits held, then a normal reinitialisation.
        do_reset("mid");
        cycle("re_init", 2'b01, 4'b0000, 16'h0000, 6'b100000, 2'd2, 4'd0, 1'b1, 2'b00, 1'b0);
        cycle("re_run", 2'b01, 4'b0000, 16'h0000, 6'b000000, 2'd0, 4'd0, 1'b0, 2'b01, 1'b1);
        check_val("re_inf", 32'(bus.CRDT_INFINITE), 32'h1F);
        check_val("re_ph", 32'(dut.u_cnt_ph.cnt_q), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pcie_crdt_up_tracker.md
# pcie_crdt_up_tracker

Credit-gated transmit arbiter for the PCIe UP (CC+RQ) direction of the R-Tile Avalon-ST path. It accumulates link-partner credits from the credit-update interface during and after initialisation. Per cycle, it grants an in-order prefix of up to SEGMENTS TLP starts whose header and data credits fit, and debits the consumed credits. It generalises the fixed two-segment credit check into parametrised segment count and counter widths, and adds infinite-credit detection per credit type.

## Interface
Parameters:
- SEGMENTS, 2, TLP-start segments per AVST word (1..4)
- H_CNT_W, 2, width of header-credit update count
- D_CNT_W, 4, width of data-credit update count
- H_CRDT_W, 8, header credit counter width
- D_CRDT_W, 12, data credit counter width (unit 16 B)
- REQ_D_W, 8, per-segment required data credits width

Ports (one clock PCIE_CLK; reset PCIE_RESET is synchronous, active-high):
- PCIE_CLK  in  1  clock
- PCIE_RESET  in  1  synchronous active-high reset
- CRDT_INIT_DONE  in  1  partner finished initial credit advertisement
- CRDT_UPDATE  in  6  update valid, MSB..LSB = PH,NPH,CPLH,PD,NPD,CPLD
- CRDT_CNT_PH / CRDT_CNT_NPH / CRDT_CNT_CPLH  in  H_CNT_W each  header credits returned
- CRDT_CNT_PD / CRDT_CNT_NPD / CRDT_CNT_CPLD  in  D_CNT_W each  data credits returned
- REQ_VLD  in  SEGMENTS  segment s holds a TLP start
- REQ_TYPE  in  SEGMENTS*2  per segment: 0=P, 1=NP, 2=CPL, 3=reserved
- REQ_DCRDT  in  SEGMENTS*REQ_D_W  data credits required by segment s (0 = no payload)
- REQ_GRANT  out  SEGMENTS  segment s may be transmitted this cycle
- CRDT_READY  out  1  tracker in RUN state
- CRDT_INFINITE  out  6  per-type infinite flag, same bit order as CRDT_UPDATE

## Operation
- States: INIT, then RUN. Reset enters INIT. INIT goes to RUN on the first cycle CRDT_INIT_DONE=1. RUN persists until reset; a later drop of INIT_DONE is ignored.
- INIT: every asserted CRDT_UPDATE bit adds its count to the matching counter. REQ_GRANT=0.
- INIT→RUN transition cycle: each counter equal to 0 (including that cycle's update) sets its CRDT_INFINITE bit, registered. Infinite types are never debited and never block.
- RUN grant rule: segments are evaluated in ascending order. Segment s is granted iff REQ_VLD[s]=1, all lower valid segments are granted, type≠3, and the cumulative demand fits the registered counter values:
  - demand = 1 header credit of its type plus REQ_DCRDT of its data type (PD/NPD/CPLD);
  - cumulative demand includes all lower granted segments.
- First failing valid segment blocks all higher segments. Invalid segments neither block nor consume.
- Type 3: never granted, blocks higher segments.
- Counter next = current − granted consumption + update count. Addition saturates at all-ones.
- Subtraction cannot underflow by construction.
- Update and consumption in the same cycle are both applied.

## Timing
- REQ_GRANT is combinational from REQ_* and registered counters (0-cycle latency). Callers hold requests until granted.
- Updates become visible to grant decisions 1 cycle after CRDT_UPDATE.
- CRDT_READY rises 1 cycle after CRDT_INIT_DONE is sampled in INIT. CRDT_INFINITE is valid from the same cycle.
- Reset values:
  - state = INIT;
  - all counters = 0;
  - CRDT_READY = 0;
  - CRDT_INFINITE = 0;
  - REQ_GRANT = 0.
- Reset mid-operation discards all credits and flags and returns to INIT.

## Configuration
- PCIE_CRDT_STALL_CNT_EN defined:
  - adds output CRDT_STALL_CNT (32 bit);
  - counts RUN cycles where any REQ_VLD bit has REQ_GRANT=0;
  - saturates at all-ones and resets to 0.
- Undefined: port and counter absent; grant behaviour identical.

## Structure
- Package pcie_crdt_pkg holds:
  - TLP type encoding constants;
  - CRDT_UPDATE bit indices;
  - state enum;
  - saturating-add function.
- Sub-module pcie_crdt_counter: one credit counter with saturating add, debit port, and infinite flag. The block instantiates 6 of them, header instances with H_CRDT_W and data instances with D_CRDT_W.
- Grant prefix computation is a generate loop over SEGMENTS in the top.

## Test plan
- INIT gating: REQ_VLD=2'b11 with PH updates of 3 during INIT → REQ_GRANT=0 until one cycle after INIT_DONE; CRDT_READY rises then.
- Infinite detect: INIT grants PH=4, PD=16, others 0, then INIT_DONE → CRDT_INFINITE=6'b011011. Repeated CPL requests are always granted and CPLH stays 0.
- Prefix block: PH=1, PD=8; seg0 P with 4 D, seg1 P with 2 D → grant 2'b01; next cycle PH=0 and PD=4.
- Data limit: PH=2, PD=5; seg0 P with 3 D, seg1 P with 3 D → grant 2'b01. Seg1 is granted the cycle after a PD update of 1.
- Simultaneous event: PH=1; grant seg0 in the same cycle as PH update +3 → next-cycle PH=3. Saturation: at PH=8'hFF an update of +2 leaves PH=8'hFF.
- Reset mid-run: PCIE_RESET asserted with credits held → next cycle counters 0, INFINITE=0, READY=0, grants 0. Reinitialisation works normally.
